// File: rtl/axi_wr_burst_if.sv
// AXI4 write-channel bundle (AW/W/B) between axi_wr_burst and host memory.
interface axi_wr_burst_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_wr_burst.sv
// AXI4 write master: upstream burst request + beat stream -> AW/W/B, one burst in flight.
// Define WR_SKID_EN to register the W path through a two-entry skid buffer.
module axi_wr_burst #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_req,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [7:0]              wr_len,
  output logic                    wr_req_ack,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_strobe,
  input  logic                    wr_wvalid,
  input  logic                    wr_last,
  output logic                    wr_ready,
  input  logic                    wr_bready,
  output logic                    wr_done,
  axi_wr_burst_if.master          m_axi,
  output logic                    err_last,
  output logic                    err_resp
);
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_B} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  ack_q, ack_d;
  logic                  done_q, done_d;
  logic                  err_last_q, err_last_d;
  logic                  err_resp_q, err_resp_d;

  logic in_w;
  logic in_hs;
  logic out_hs;
  logic beat_last;
  logic out_last_hs;
  logic unused_ok;

  assign in_w        = (state_q == S_W);
  assign in_hs       = wr_wvalid & wr_ready;
  assign out_hs      = m_axi.wvalid & m_axi.wready;
  // beat_cnt tracks beats accepted from upstream; this flags the final one of the burst
  assign beat_last   = (beat_cnt_q == awlen_q);
  assign out_last_hs = out_hs & m_axi.wlast;
  assign unused_ok   = &{1'b0, wr_bready, wr_addr[5:0]};

`ifdef WR_SKID_EN
  logic [DATA_WIDTH-1:0]   skid_data_q [0:1];
  logic [DATA_WIDTH/8-1:0] skid_strb_q [0:1];
  logic                    skid_last_q [0:1];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              cnt_q, cnt_d;
  logic                    in_done_q, in_done_d;

  // Upstream side sees only occupancy, never m_axi.wready
  assign wr_ready     = in_w & ~in_done_q & (cnt_q != 2'd2);
  assign m_axi.wvalid = (cnt_q != 2'd0);
  assign m_axi.wdata  = skid_data_q[rd_ptr_q];
  assign m_axi.wstrb  = skid_strb_q[rd_ptr_q];
  assign m_axi.wlast  = (cnt_q != 2'd0) & skid_last_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (in_hs) begin
      skid_data_q[wr_ptr_q] <= wr_data;
      skid_strb_q[wr_ptr_q] <= wr_strobe;
      skid_last_q[wr_ptr_q] <= beat_last;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q ^ in_hs;
    rd_ptr_d  = rd_ptr_q ^ out_hs;
    cnt_d     = cnt_q + {1'b0, in_hs} - {1'b0, out_hs};
    in_done_d = in_done_q;
    if (in_hs && beat_last) begin
      in_done_d = 1'b1;
    end
    if (out_last_hs) begin
      in_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      in_done_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      in_done_q <= in_done_d;
    end
  end
`else
  assign wr_ready     = in_w & m_axi.wready;
  assign m_axi.wvalid = in_w & wr_wvalid;
  assign m_axi.wdata  = wr_data;
  assign m_axi.wstrb  = wr_strobe;
  assign m_axi.wlast  = in_w & beat_last;
`endif

  always_comb begin
    state_d    = state_q;
    awaddr_d   = awaddr_q;
    awlen_d    = awlen_q;
    beat_cnt_d = beat_cnt_q;
    ack_d      = 1'b0;
    done_d     = 1'b0;
    err_last_d = err_last_q;
    err_resp_d = err_resp_q;

    if (in_hs) begin
      beat_cnt_d = beat_last ? 8'd0 : beat_cnt_q + 8'd1;
      if (wr_last != beat_last) begin
        err_last_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (wr_req) begin
          awaddr_d = {wr_addr[ADDR_WIDTH-1:6], 6'b0};
          awlen_d  = wr_len;
          ack_d    = 1'b1;
          state_d  = S_AW;
        end
      end
      S_AW: begin
        if (m_axi.awready) begin
          state_d = S_W;
        end
      end
      S_W: begin
        if (out_last_hs) begin
          state_d = S_B;
        end
      end
      S_B: begin
        if (m_axi.bvalid) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (m_axi.bresp != 2'b00) begin
            err_resp_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      awaddr_q   <= '0;
      awlen_q    <= 8'd0;
      beat_cnt_q <= 8'd0;
      ack_q      <= 1'b0;
      done_q     <= 1'b0;
      err_last_q <= 1'b0;
      err_resp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      awaddr_q   <= awaddr_d;
      awlen_q    <= awlen_d;
      beat_cnt_q <= beat_cnt_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_last_q <= err_last_d;
      err_resp_q <= err_resp_d;
    end
  end

  assign wr_req_ack    = ack_q;
  assign wr_done       = done_q;
  assign err_last      = err_last_q;
  assign err_resp      = err_resp_q;
  assign m_axi.awvalid = (state_q == S_AW);
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.awsize  = 3'b110;
  assign m_axi.awburst = 2'b01;
  assign m_axi.bready  = (state_q == S_B);
endmodule

// File: doc/axi_wr_burst.md
Name: axi_wr_burst

Overview:
- AXI4 write master that sits directly downstream of the decompressor I/O wrapper.
- Converts its write-side handshake (wr_req/addr/len, beat stream with strobes, last, done) into AXI4 AW/W/B channel traffic toward host memory.
- One burst in flight at a time.
- Generates WLAST from its own beat counter and reports protocol and response errors as sticky flags.

Parameters:
- ADDR_WIDTH, 64, address width of host memory.
- DATA_WIDTH, 512, beat width in bits; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  burst request from upstream
- wr_addr  in  ADDR_WIDTH  burst start address, 64B aligned
- wr_len  in  8  beats minus one (AXI convention)
- wr_req_ack  out  1  one-cycle pulse: request captured
- wr_data  in  DATA_WIDTH  beat data
- wr_strobe  in  DATA_WIDTH/8  byte enables
- wr_wvalid  in  1  beat valid
- wr_last  in  1  upstream marks final beat of burst
- wr_ready  out  1  beat accepted when wr_wvalid&wr_ready
- wr_bready  in  1  upstream ready for completion (informational)
- wr_done  out  1  one-cycle pulse: burst completed (B handshake)
- m_axi_awvalid/awready  out/in  1  AW handshake
- m_axi_awaddr  out  ADDR_WIDTH
- m_axi_awlen  out  8
- m_axi_awsize  out  3  constant 3'b110
- m_axi_awburst  out  2  constant 2'b01 (INCR)
- m_axi_wvalid/wready  out/in  1  W handshake
- m_axi_wdata  out  DATA_WIDTH
- m_axi_wstrb  out  DATA_WIDTH/8
- m_axi_wlast  out  1
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- m_axi_bresp  in  2
- err_last  out  1  sticky: wr_last disagreed with beat counter
- err_resp  out  1  sticky: bresp != 2'b00

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All valid/ready/ack/done outputs 0, err_* 0, beat counter 0.
  - awaddr and awlen are 0.
  - Reset mid-burst abandons the transaction; no completion is reported.
- FSM:
  - IDLE: if wr_req, latch awaddr = {wr_addr[ADDR_WIDTH-1:6], 6'b0} and awlen = wr_len, pulse wr_req_ack for 1 cycle, go to AW next cycle.
  - AW: awvalid=1, held with stable addr/len until awready; on handshake go to W.
  - W: beats pass through.
    - m_axi_wvalid = wr_wvalid, wr_ready = m_axi_wready.
    - wdata/wstrb are wired from wr_data/wr_strobe.
    - m_axi_wlast = (beat_cnt == awlen).
    - beat_cnt increments on each m_axi_wvalid&m_axi_wready.
    - On the handshake of the beat with wlast, clear beat_cnt and go to B.
  - B: m_axi_bready=1. On bvalid: pulse wr_done 1 cycle, set err_resp if bresp!=0, return to IDLE.
- wr_req arriving outside IDLE is not acked; the requester holds wr_req until acked.
- Minimum gap between bursts: request-to-ack 1 cycle, so back-to-back requests are acked no faster than once per completed burst.
- err_last: set on any accepted beat where wr_last != m_axi_wlast. The burst still completes using the counter's WLAST.
- wr_ready and m_axi_wvalid are 0 in IDLE, AW and B. No beat is ever accepted before the AW handshake.
- awlen=0: a single beat with wlast=1.
- awlen=255: 256 beats; beat_cnt is 8 bits and must not wrap before wlast.
- err_* clear only on reset.

Optional Feature:
- Macro WR_SKID_EN.
- Defined: a two-entry skid buffer registers the W path (data, strobe, last).
  - wr_ready derives from buffer occupancy rather than m_axi_wready, giving no combinational path from wready to wr_ready.
  - Adds 1 cycle of latency; full throughput is sustained at 1 beat/cycle.
  - FSM leaves W only after the wlast beat drains from the buffer.
- Undefined: the combinational passthrough described above.

Test Plan:
- wr_addr=0x1000_0040, wr_len=3, 4 beats with continuous valid/wready -> one wr_req_ack pulse; awaddr=0x1000_0040, awlen=3; wlast on beat 4 only; wr_done 1 cycle after bvalid; err_* stay 0.
- wr_addr=0x2000_0013 -> awaddr=0x2000_0000.
- wr_len=0 with awready delayed 5 cycles -> awvalid held stable for 6 cycles; wr_ready stays 0 until after the AW handshake; one beat with wlast=1.
- wr_len=7 with wready toggled every other cycle and wr_last asserted on beat 6 -> exactly 8 beats transferred; wlast on beat 8; err_last=1.
- bresp=2'b10 -> wr_done pulses and err_resp=1 remains set through the next clean burst.
- Reset asserted during the W state after 2 of 4 beats -> all outputs return to 0 asynchronously; next wr_req after reset is acked and completes normally.
- With WR_SKID_EN defined: 256-beat burst with random wready -> data order preserved, no beats lost or duplicated.
